// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot stream encoder and its priority finder.
package onehot_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Index width for a vector of w bits; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // True when exactly one bit of vec is set.
    function automatic logic popcount_is_one(input logic [63:0] vec);
        return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/onehot_stream_encoder_prio_find.sv
// Fixed-priority search: index of the lowest (or highest) set bit of vec.
module prio_find
    import onehot_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan towards the winning end so the final match is the priority one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/onehot_stream_encoder.sv
// Multi-hot to binary-index stream encoder: accepts a vector, then emits the
// index of every set bit, one per output handshake, flagging the final one.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new vector; zero vectors are consumed silently
// DRAIN | emitting indices of the pending mask, one per out handshake
module onehot_stream_encoder
    import onehot_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] res_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_found;
    logic             last_bit;
    logic [WIDTH-1:0] clr_mask;

    prio_find #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_find (
        .vec   (pending_q),
        .idx   (hit_idx),
        .found (hit_found)
    );

    // Outputs depend only on the registered mask, never on in_vec.
    assign last_bit = popcount_is_one(64'(pending_q));
    assign clr_mask = ONE << hit_idx;
    assign res_num  = hit_idx;

    // State and pending-mask registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state, mask update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (in_vec != '0)) begin
                    pending_d = in_vec;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = hit_found;
                out_last  = last_bit;
                if (!hit_found) begin
                    // Unreachable in normal operation; recover rather than hang.
                    state_d = IDLE;
                end else if (out_ready) begin
                    pending_d = pending_q & ~clr_mask;
                    if (last_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

endmodule
